axi4_basic_slave_responder: RTL and testbench

- AXI4 slave endpoint with no memory model; terminates all traffic from an AXI master in the subsystem.
- Accepts write bursts and returns a write response.
- Answers read bursts with deterministic, address-derived data, so checkers can predict every beat.
- Write and read channels run independently; each channel handles one outstanding burst at a time.

---
 rtl/axi4_pkg.sv | 38 +++
 rtl/axi4_beat_addr_gen.sv | 24 ++
 rtl/axi4_basic_slave_responder.sv | 196 +++++++++++++++++++
 tb/tb_axi4_basic_slave_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 burst/response types and beat address helper
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Address is carried at 64 bits so every AXI block can share one helper.
    // The reserved burst encoding falls through to INCR.
    function automatic logic [63:0] next_beat_addr(
        input logic [63:0] addr,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [63:0] incr;
        logic [63:0] nxt;
        logic [63:0] wrap_bytes;
        logic [63:0] mask;
        incr       = 64'd1 << size;
        nxt        = addr + incr;
        wrap_bytes = ({56'd0, len} + 64'd1) << size;
        mask       = wrap_bytes - 64'd1;
        case (burst)
            2'b00:   next_beat_addr = addr;
            2'b10:   next_beat_addr = (addr & ~mask) | (nxt & mask);
            default: next_beat_addr = nxt;
        endcase
    endfunction

endpackage

// File: rtl/axi4_beat_addr_gen.sv
// rtl/axi4_beat_addr_gen.sv - combinational next-beat address for a burst
module axi4_beat_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [63:0] nxt_wide;
    logic        unused_hi;

    always_comb begin
        nxt_wide = next_beat_addr(64'(addr), size, len, burst);
    end

    assign next_addr = nxt_wide[ADDR_W-1:0];
    assign unused_hi = ^nxt_wide;

endmodule

// File: rtl/axi4_basic_slave_responder.sv
// rtl/axi4_basic_slave_responder.sv - AXI4 sink: absorbs writes, answers reads with address-derived data
module axi4_basic_slave_responder
    import axi4_pkg::*;
#(
    parameter int          ID_W       = 4,
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter logic [31:0] RD_PATTERN = 32'hA5A5_0000
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_W-1:0]     s_awid,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_W-1:0]     s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_W-1:0]     s_rid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
    localparam int         WIDE_W   = ADDR_W + DATA_W + 32;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    w_state_e          w_state;
    logic [ID_W-1:0]   w_id;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic              w_err;
    logic              w_last_beat;
    logic              w_beat_err;

    r_state_e          r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_beat;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] r_data_addr;
    logic [WIDE_W-1:0] r_word;
    logic [2:0]        ar_size_clamped;
    logic              unused_inputs;

    assign unused_inputs = ^{s_awaddr, s_awsize, s_awburst, s_wdata, s_wstrb, r_word};

    // Write path: data is dropped, only the beat count and wlast placement matter.
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_err  = (s_wlast != w_last_beat);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state   <= W_IDLE;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bid     <= '0;
            s_bresp   <= RESP_OKAY;
            w_id      <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_err     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_awready <= 1'b1;
                    if (s_awvalid && s_awready) begin
                        s_awready <= 1'b0;
                        s_wready  <= 1'b1;
                        w_id      <= s_awid;
                        w_len     <= s_awlen;
                        w_cnt     <= '0;
                        w_err     <= 1'b0;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_wvalid && s_wready) begin
                        w_cnt <= w_cnt + 8'd1;
                        w_err <= w_err | w_beat_err;
                        if (w_last_beat || s_wlast) begin
                            s_wready <= 1'b0;
                            s_bvalid <= 1'b1;
                            s_bid    <= w_id;
                            s_bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        s_bvalid  <= 1'b0;
                        s_bresp   <= RESP_OKAY;
                        s_awready <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read path: rdata is registered, so it is computed from the address the
    // next beat will carry (the AR address on accept, the stepped one otherwise).
    assign ar_size_clamped = (s_arsize > MAX_SIZE) ? MAX_SIZE : s_arsize;
    assign r_data_addr     = (r_state == R_IDLE) ? s_araddr : r_next_addr;
    assign r_word          = WIDE_W'(r_data_addr) ^ WIDE_W'(RD_PATTERN);

    axi4_beat_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_beat_addr_gen (
        .addr      (r_addr),
        .size      (r_size),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_next_addr)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= R_IDLE;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rid     <= '0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
            s_rlast   <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_beat    <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_arready <= 1'b1;
                    if (s_arvalid && s_arready) begin
                        s_arready <= 1'b0;
                        s_rvalid  <= 1'b1;
                        s_rid     <= s_arid;
                        s_rdata   <= r_word[DATA_W-1:0];
                        s_rresp   <= RESP_OKAY;
                        s_rlast   <= (s_arlen == 8'd0);
                        r_addr    <= s_araddr;
                        r_len     <= s_arlen;
                        r_size    <= ar_size_clamped;
                        r_burst   <= s_arburst;
                        r_beat    <= '0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_rready) begin
                        if (s_rlast) begin
                            s_rvalid  <= 1'b0;
                            s_rlast   <= 1'b0;
                            s_arready <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_addr  <= r_next_addr;
                            s_rdata <= r_word[DATA_W-1:0];
                            r_beat  <= r_beat + 8'd1;
                            s_rlast <= ((r_beat + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_basic_slave_responder.sv
// tb/tb_axi4_basic_slave_responder.sv - scoreboard bench for axi4_basic_slave_responder
module tb_axi4_basic_slave_responder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [3:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [3:0]  s_arid;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } r_exp_t;

    r_exp_t     rq[$];
    logic [5:0] bq[$];
    int         checks   = 0;
    int         failures = 0;
    int         bp_mode  = 0;

    axi4_basic_slave_responder dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_awid    (s_awid),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .s_awsize  (s_awsize),
        .s_awburst (s_awburst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bid     (s_bid),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sole driver of rready/bready: 0 = both high, 1 = random, 2 = bready held low.
    initial begin
        s_rready = 1'b1;
        s_bready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (bp_mode)
                1: begin
                    s_rready = 1'($urandom_range(0, 1));
                    s_bready = 1'($urandom_range(0, 1));
                end
                2: begin
                    s_rready = 1'b1;
                    s_bready = 1'b0;
                end
                default: begin
                    s_rready = 1'b1;
                    s_bready = 1'b1;
                end
            endcase
        end
    end

    // Monitor: pops expectations on handshakes and checks hold-while-stalled.
    logic        r_stall = 1'b0;
    logic        b_stall = 1'b0;
    logic [36:0] r_prev;
    logic [5:0]  b_prev;
    always @(negedge aclk) begin
        if (!aresetn) begin
            r_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (r_stall)
                chk("r_hold", {s_rvalid, s_rid, s_rdata, s_rlast}, {1'b1, r_prev});
            if (b_stall)
                chk("b_hold", {s_bvalid, s_bid, s_bresp}, {1'b1, b_prev});
            if (s_rvalid && s_rready) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected_beat", {s_rid, s_rdata, s_rlast}, 37'd0 - 37'd1);
                end else begin
                    r_exp_t e;
                    e = rq.pop_front();
                    chk("r_beat", {s_rid, s_rdata, s_rlast}, e);
                    chk("r_resp", s_rresp, 2'b00);
                end
            end
            if (s_bvalid && s_bready) begin
                if (bq.size() == 0)
                    chk("b_unexpected", {s_bid, s_bresp}, 6'h3f);
                else
                    chk("b_resp", {s_bid, s_bresp}, bq.pop_front());
            end
            r_stall = s_rvalid && !s_rready;
            b_stall = s_bvalid && !s_bready;
            r_prev  = {s_rid, s_rdata, s_rlast};
            b_prev  = {s_bid, s_bresp};
        end
    end

    task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic last);
        r_exp_t e;
        e.id   = id;
        e.data = data;
        e.last = last;
        rq.push_back(e);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [7:0] len);
        int n = 0;
        s_awid = id; s_awaddr = 32'h100; s_awlen = len; s_awsize = 3'd2; s_awburst = 2'b01;
        s_awvalid = 1'b1;
        while (!s_awready && n < 100) begin @(posedge aclk); #1; n++; end
        chk("aw_ready", s_awready, 1'b1);
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic last, input logic final_beat);
        int n = 0;
        s_wdata = $urandom; s_wstrb = 4'hf; s_wlast = last; s_wvalid = 1'b1;
        while (!s_wready && n < 100) begin @(posedge aclk); #1; n++; end
        chk("w_ready", s_wready, 1'b1);
        @(posedge aclk); #1;
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        if (final_beat)
            chk("b_latency", s_bvalid, 1'b1);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1;
        while (!s_arready && n < 100) begin @(posedge aclk); #1; n++; end
        chk("ar_ready", s_arready, 1'b1);
        @(posedge aclk); #1;
        s_arvalid = 1'b0;
        chk("r_latency", s_rvalid, 1'b1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 2000) begin @(posedge aclk); #1; n++; end
        chk(name, rq.size() + bq.size(), 0);
    endtask

    task automatic check_idle_ready(input string name);
        @(posedge aclk); #1;
        chk(name, {s_awready, s_arready}, 2'b11);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_wlast = 1'b0;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_wdata = '0; s_wstrb = '0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;

        repeat (5) @(posedge aclk);
        #1;
        chk("reset_outputs", {s_awready, s_wready, s_bvalid, s_bid, s_bresp, s_arready,
                              s_rvalid, s_rid, s_rdata, s_rresp, s_rlast}, 0);
        aresetn = 1'b1;
        check_idle_ready("ready_after_reset");

        // Single write with bready held low for three cycles
        bp_mode = 2;
        repeat (2) @(posedge aclk);
        #1;
        bq.push_back({4'h7, 2'b00});
        send_aw(4'h7, 8'd0);
        send_w(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1;
            chk("b_held", {s_bvalid, s_bid, s_bresp}, {1'b1, 4'h7, 2'b00});
        end
        bp_mode = 0;
        drain("single_write_drain");

        // INCR read
        push_r(4'h9, 32'hA5A51000, 1'b0);
        push_r(4'h9, 32'hA5A51004, 1'b0);
        push_r(4'h9, 32'hA5A51008, 1'b0);
        push_r(4'h9, 32'hA5A5100C, 1'b1);
        send_ar(4'h9, 32'h1000, 8'd3, 3'd2, 2'b01);
        drain("incr_read_drain");

        // WRAP read
        push_r(4'h3, 32'hA5A51008, 1'b0);
        push_r(4'h3, 32'hA5A5100C, 1'b0);
        push_r(4'h3, 32'hA5A51000, 1'b0);
        push_r(4'h3, 32'hA5A51004, 1'b1);
        send_ar(4'h3, 32'h1008, 8'd3, 3'd2, 2'b10);
        drain("wrap_read_drain");

        // FIXED read, oversize arsize clamp, reserved burst as INCR
        push_r(4'h1, 32'hA5A50020, 1'b0);
        push_r(4'h1, 32'hA5A50020, 1'b0);
        push_r(4'h1, 32'hA5A50020, 1'b1);
        send_ar(4'h1, 32'h20, 8'd2, 3'd2, 2'b00);
        drain("fixed_read_drain");
        push_r(4'h2, 32'hA5A50040, 1'b0);
        push_r(4'h2, 32'hA5A50044, 1'b1);
        send_ar(4'h2, 32'h40, 8'd1, 3'd5, 2'b01);
        drain("clamp_read_drain");
        push_r(4'h4, 32'hA5A50050, 1'b0);
        push_r(4'h4, 32'hA5A50054, 1'b1);
        send_ar(4'h4, 32'h50, 8'd1, 3'd2, 2'b11);
        drain("reserved_read_drain");

        // Early wlast, then missing wlast on the final beat
        bq.push_back({4'h2, 2'b10});
        send_aw(4'h2, 8'd3);
        send_w(1'b0, 1'b0);
        send_w(1'b1, 1'b1);
        drain("early_wlast_drain");
        check_idle_ready("idle_after_slverr");
        bq.push_back({4'h5, 2'b10});
        send_aw(4'h5, 8'd1);
        send_w(1'b0, 1'b0);
        send_w(1'b0, 1'b1);
        drain("missing_wlast_drain");

        // Concurrent write and read under random backpressure
        bp_mode = 1;
        fork
            begin
                bq.push_back({4'h3, 2'b00});
                send_aw(4'h3, 8'd3);
                send_w(1'b0, 1'b0);
                send_w(1'b0, 1'b0);
                send_w(1'b0, 1'b0);
                send_w(1'b1, 1'b1);
            end
            begin
                for (int i = 0; i < 8; i++)
                    push_r(4'h5, 32'hA5A52000 + 32'(4 * i), (i == 7));
                send_ar(4'h5, 32'h2000, 8'd7, 3'd2, 2'b01);
            end
        join
        drain("concurrent_drain");

        // Reset pulsed mid-read aborts the burst
        bp_mode = 0;
        for (int i = 0; i < 8; i++)
            push_r(4'h6, 32'hA5A53000 + 32'(4 * i), (i == 7));
        send_ar(4'h6, 32'h3000, 8'd7, 3'd2, 2'b01);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #2;
        chk("midburst_reset_outputs", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                                       s_rdata, s_rlast}, 0);
        rq.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        check_idle_ready("ready_after_midburst_reset");
        push_r(4'h8, 32'hA5A50400, 1'b1);
        send_ar(4'h8, 32'h400, 8'd0, 3'd2, 2'b01);
        drain("post_reset_read_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
